logic_axi4_stream_unpacker: RTL and testbench
=============================================

// Module: logic_axi4_stream_unpacker
//
// PURPOSE
// - Receive-side counterpart of a width upsizer: accepts wide AXI4-Stream beats and emits them as narrow beats.
// - Slices are emitted lowest byte lane first, and null slices (all tkeep bits clear) are compressed out.
// - Placed where an upsized or packed wide stream must be consumed by a narrow-datapath block.
// - Registered in both directions: one holding buffer plus a slice-select state machine.
//
// PARAMETERS
// - RX_TDATA_BYTES  4  rx tdata width in bytes; must be an integer multiple of TX_TDATA_BYTES
// - TX_TDATA_BYTES  1  tx tdata width in bytes; N = RX_TDATA_BYTES/TX_TDATA_BYTES, N >= 2 (elaboration $error otherwise)
// - TUSER_WIDTH     1  tuser width in bits; copied to every tx slice
// - TDEST_WIDTH     1  tdest width in bits; copied to every tx slice
// - TID_WIDTH       1  tid width in bits; copied to every tx slice
//
// PORTS
// - aclk        in   1          clock; all logic on its rising edge
// - areset      in   1          asynchronous, active-high reset
// - rx_tvalid   in   1          rx beat valid
// - rx_tready   out  1          rx beat accepted when rx_tvalid & rx_tready
// - rx_tdata    in   8*RX_B     rx data; lane k = bits [8k+7:8k]
// - rx_tkeep    in   RX_B       rx byte-keep
// - rx_tstrb    in   RX_B       rx byte-strobe
// - rx_tlast    in   1          rx packet end
// - rx_tuser    in   TUSER_W    rx user
// - rx_tdest    in   TDEST_W    rx destination
// - rx_tid      in   TID_W      rx id
// - tx_tvalid   out  1          tx slice valid
// - tx_tready   in   1          tx slice accepted when tx_tvalid & tx_tready
// - tx_tdata    out  8*TX_B     slice s = rx bytes [s*TX_B +: TX_B]
// - tx_tkeep    out  TX_B       slice keep
// - tx_tstrb    out  TX_B       slice strobe
// - tx_tlast    out  1          set only on the final emitted slice of an rx beat that had tlast
// - tx_tuser    out  TUSER_W    registered copy of rx_tuser
// - tx_tdest    out  TDEST_W    registered copy of rx_tdest
// - tx_tid      out  TID_W      registered copy of rx_tid
//
// BEHAVIOUR
// - Reset values: tx_tvalid=0, tx_tlast=0, rx_tready=0 while areset=1; buffer, mask and index all 0.
// - rx_tready rises in the first cycle after areset deasserts.
// - States:
//   - EMPTY: rx_tready=1, tx_tvalid=0.
//   - BUSY: tx_tvalid=1; slice index idx selects the tx slice.
// - Accept in EMPTY:
//   - Latch the rx beat.
//   - Build pending mask M[s] = |rx_tkeep[s*TX_B +: TX_B].
//   - Set idx = lowest set bit of M and go to BUSY.
//   - Latency is 1 cycle from rx accept to tx_tvalid.
// - All-null beat (M==0):
//   - rx_tlast=0: drop the beat and stay EMPTY; nothing is emitted.
//   - rx_tlast=1: emit exactly one slice, idx=0, tkeep=0, tlast=1.
// - In BUSY, on a tx handshake, clear M[idx] and set idx = next set bit above idx.
// - Last slice = no set bit above idx. tx_tlast = buffered tlast & last slice.
// - rx_tready=1 in BUSY only during the handshake of the last slice.
//   - A new beat is then loaded in the same cycle, giving zero-bubble back-to-back operation.
//   - Otherwise the block returns to EMPTY.
// - tx outputs are held stable while tx_tvalid=1 and tx_tready=0.
// - Full throughput is one tx slice per cycle when all slices are kept.
// - idx width is $clog2(N). idx never wraps: the beat ends at the last set mask bit.
// - tstrb and tkeep pass through per slice. tstrb is not used for skipping.
// - areset mid-beat discards the buffered beat; no partial slices are emitted after reset.
//
// CONFIGURATION
// - Macro LOGIC_AXI4_STREAM_UNPACKER_NULL_SKIP_EN.
//   - Defined: null-slice compression as described in BEHAVIOUR.
//   - Undefined: M is forced to all ones, so all N slices are always emitted in order, null slices included.
//     - tlast goes on slice N-1.
//     - An all-null beat is emitted in full and is never dropped.
//
// TESTING
// - N=4, rx tdata=0x44332211, tkeep=0xF, tlast=1, tx_tready=1
//   -> tx emits 0x11,0x22,0x33,0x44 on 4 consecutive cycles; tlast only on 0x44.
// - Same beat, tkeep=0x5 (NULL_SKIP_EN defined)
//   -> tx emits 0x11, then 0x33 with tlast=1.
//   - Without the macro: 4 slices; tkeep 1,0,1,0; tlast on slice 3.
// - Two back-to-back beats with tkeep=0xF and tx_tready=1
//   -> 8 tx slices with no idle cycle; rx_tready pulses only on slice 3.
// - tkeep=0x0, tlast=0, then tkeep=0x0, tlast=1 (macro defined)
//   -> first beat produces nothing; second produces one slice with tkeep=0, tlast=1.
// - Randomised tx_tready stalls
//   -> no data change while stalled; tuser/tdest/tid equal the rx values on every slice.
// - Assert areset during slice 2 of a 4-slice beat
//   -> tx_tvalid=0 immediately; after release, rx_tready=1 and the next beat starts at its slice 0.

Source files
------------

// File: rtl/logic_axi4_stream_unpacker_if.sv
// AXI4-Stream bundle used on both sides of logic_axi4_stream_unpacker.
// DATA_BYTES sets the tdata width; tuser/tdest/tid widths are parameters.
interface logic_axi4_stream_unpacker_if #(
  parameter int DATA_BYTES  = 1,
  parameter int TUSER_WIDTH = 1,
  parameter int TDEST_WIDTH = 1,
  parameter int TID_WIDTH   = 1
);
  logic                     tvalid;
  logic                     tready;
  logic [8*DATA_BYTES-1:0]  tdata;
  logic [DATA_BYTES-1:0]    tkeep;
  logic [DATA_BYTES-1:0]    tstrb;
  logic                     tlast;
  logic [TUSER_WIDTH-1:0]   tuser;
  logic [TDEST_WIDTH-1:0]   tdest;
  logic [TID_WIDTH-1:0]     tid;

  modport master (output tvalid, tdata, tkeep, tstrb, tlast, tuser, tdest, tid,
                  input  tready);
  modport slave  (input  tvalid, tdata, tkeep, tstrb, tlast, tuser, tdest, tid,
                  output tready);
endinterface

// File: rtl/logic_axi4_stream_unpacker.sv
// Wide-to-narrow AXI4-Stream unpacker: one holding buffer plus a slice-select FSM.
// Define LOGIC_AXI4_STREAM_UNPACKER_NULL_SKIP_EN to compress out slices with no kept bytes.
//
// state | meaning
// EMPTY | buffer free, rx_tready=1 once out of reset
// BUSY  | buffered beat being emitted, idx selects the current tx slice
module logic_axi4_stream_unpacker #(
  parameter int RX_TDATA_BYTES = 4,
  parameter int TX_TDATA_BYTES = 1,
  parameter int TUSER_WIDTH    = 1,
  parameter int TDEST_WIDTH    = 1,
  parameter int TID_WIDTH      = 1
) (
  input logic                          aclk,
  input logic                          areset,
  logic_axi4_stream_unpacker_if.slave  rx,
  logic_axi4_stream_unpacker_if.master tx
);
  localparam int N     = RX_TDATA_BYTES / TX_TDATA_BYTES;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int RX_W  = 8 * RX_TDATA_BYTES;
  localparam int TX_W  = 8 * TX_TDATA_BYTES;

  if ((RX_TDATA_BYTES % TX_TDATA_BYTES) != 0 || N < 2) begin : g_param_check
    $error("RX_TDATA_BYTES must be a multiple (>=2x) of TX_TDATA_BYTES");
  end

  typedef enum logic {EMPTY, BUSY} state_t;

  state_t                   state_q, state_d;
  logic                     init_q;
  logic [RX_W-1:0]          data_q;
  logic [RX_TDATA_BYTES-1:0] keep_q, strb_q;
  logic                     last_q;
  logic [TUSER_WIDTH-1:0]   user_q;
  logic [TDEST_WIDTH-1:0]   dest_q;
  logic [TID_WIDTH-1:0]     id_q;
  logic [N-1:0]             mask_q, mask_in, mask_rest;
  logic [IDX_W-1:0]         idx_q;
  logic                     last_slice, load, rx_ready;

  function automatic logic [IDX_W-1:0] lowest_set(input logic [N-1:0] m);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int s = N - 1; s >= 0; s--) begin
      if (m[s]) r = IDX_W'(s);
    end
    return r;
  endfunction

  always_comb begin
    mask_in = '0;
`ifdef LOGIC_AXI4_STREAM_UNPACKER_NULL_SKIP_EN
    for (int s = 0; s < N; s++) begin
      mask_in[s] = |rx.tkeep[s*TX_TDATA_BYTES +: TX_TDATA_BYTES];
    end
`else
    mask_in = '1;
`endif
  end

  // Lanes below idx are already cleared, so the rest of the mask tells if idx is last.
  assign mask_rest  = mask_q & ~(N'(1) << idx_q);
  assign last_slice = (mask_rest == '0);

  always_comb begin
    state_d  = state_q;
    rx_ready = 1'b0;
    load     = 1'b0;
    case (state_q)
      EMPTY: begin
        rx_ready = init_q;
        load     = rx.tvalid & init_q;
      end
      BUSY: begin
        if (tx.tready && last_slice) begin
          rx_ready = 1'b1;
          state_d  = EMPTY;
          load     = rx.tvalid;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (load) state_d = ((mask_in != '0) || rx.tlast) ? BUSY : EMPTY;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= EMPTY;
      init_q  <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      strb_q  <= '0;
      last_q  <= 1'b0;
      user_q  <= '0;
      dest_q  <= '0;
      id_q    <= '0;
      mask_q  <= '0;
      idx_q   <= '0;
    end else begin
      init_q  <= 1'b1;
      state_q <= state_d;
      if (load) begin
        data_q <= rx.tdata;
        keep_q <= rx.tkeep;
        strb_q <= rx.tstrb;
        last_q <= rx.tlast;
        user_q <= rx.tuser;
        dest_q <= rx.tdest;
        id_q   <= rx.tid;
        mask_q <= mask_in;
        idx_q  <= lowest_set(mask_in);
      end else if (state_q == BUSY && tx.tready) begin
        mask_q <= mask_rest;
        idx_q  <= lowest_set(mask_rest);
      end
    end
  end

  always_comb begin
    tx.tvalid = (state_q == BUSY);
    tx.tlast  = (state_q == BUSY) & last_q & last_slice;
    tx.tdata  = data_q[int'(idx_q)*TX_W +: TX_W];
    tx.tkeep  = keep_q[int'(idx_q)*TX_TDATA_BYTES +: TX_TDATA_BYTES];
    tx.tstrb  = strb_q[int'(idx_q)*TX_TDATA_BYTES +: TX_TDATA_BYTES];
    tx.tuser  = user_q;
    tx.tdest  = dest_q;
    tx.tid    = id_q;
    rx.tready = rx_ready;
  end
endmodule

// File: tb/tb_logic_axi4_stream_unpacker.sv
// Self-checking bench for logic_axi4_stream_unpacker with N=4 byte slices.
// Expected slices are built from each rx beat and compared as tx handshakes occur.
module tb_logic_axi4_stream_unpacker;
  localparam int RX_B = 4;
  localparam int TX_B = 1;
  localparam int N    = RX_B / TX_B;

  logic aclk   = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  logic_axi4_stream_unpacker_if #(.DATA_BYTES(RX_B)) rx_bus ();
  logic_axi4_stream_unpacker_if #(.DATA_BYTES(TX_B)) tx_bus ();

  logic_axi4_stream_unpacker #(
    .RX_TDATA_BYTES(RX_B), .TX_TDATA_BYTES(TX_B),
    .TUSER_WIDTH(1), .TDEST_WIDTH(1), .TID_WIDTH(1)
  ) dut (
    .aclk  (aclk),
    .areset(areset),
    .rx    (rx_bus),
    .tx    (tx_bus)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       keep;
    logic       strb;
    logic       last;
    logic       user;
    logic       dest;
    logic       id;
  } slice_t;

  slice_t exp_q[$];
  int total = 0;
  int bad   = 0;

  // Reference: which slices a beat should produce, in order.
  function automatic void push_beat(input logic [31:0] d, input logic [3:0] k,
                                    input logic [3:0] st, input logic l,
                                    input logic u, input logic de, input logic i);
    int sel[$];
    slice_t e;
    for (int s = 0; s < N; s++) begin
`ifdef LOGIC_AXI4_STREAM_UNPACKER_NULL_SKIP_EN
      if (k[s]) sel.push_back(s);
`else
      sel.push_back(s);
`endif
    end
    if (sel.size() == 0 && l) sel.push_back(0);
    for (int j = 0; j < sel.size(); j++) begin
      e.data = d[8*sel[j] +: 8];
      e.keep = k[sel[j]];
      e.strb = st[sel[j]];
      e.last = l && (j == sel.size() - 1);
      e.user = u;
      e.dest = de;
      e.id   = i;
      exp_q.push_back(e);
    end
  endfunction

  always @(negedge aclk) begin
    slice_t act, ex;
    if (!areset && tx_bus.tvalid && tx_bus.tready) begin
      act = {tx_bus.tdata, tx_bus.tkeep, tx_bus.tstrb, tx_bus.tlast,
             tx_bus.tuser, tx_bus.tdest, tx_bus.tid};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL tx_unexpected_slice got=%h required=none", act);
      end else begin
        ex = exp_q.pop_front();
        if (act !== ex) begin
          bad++;
          $display("FAIL tx_slice got=%h required=%h", act, ex);
        end
      end
    end
  end

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic [3:0] st,
                           input logic l, input logic u, input logic de, input logic i);
    int n;
    push_beat(d, k, st, l, u, de, i);
    rx_bus.tdata  = d;
    rx_bus.tkeep  = k;
    rx_bus.tstrb  = st;
    rx_bus.tlast  = l;
    rx_bus.tuser  = u;
    rx_bus.tdest  = de;
    rx_bus.tid    = i;
    rx_bus.tvalid = 1'b1;
    n = 0;
    do begin
      @(negedge aclk);
      n++;
    end while (!rx_bus.tready && n < 300);
    if (!rx_bus.tready) begin
      total++;
      bad++;
      $display("FAIL rx_accept_timeout got=0 required=1");
    end
    @(posedge aclk);
    #1;
    rx_bus.tvalid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge aclk);
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain_timeout got=%0d required=0 pending", name, exp_q.size());
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic count_run(output int n, output logic [15:0] rdy);
    int w;
    n = 0;
    rdy = '0;
    w = 0;
    do begin
      @(negedge aclk);
      w++;
    end while (!tx_bus.tvalid && w < 50);
    while (tx_bus.tvalid && tx_bus.tready && n < 16) begin
      rdy[n] = rx_bus.tready;
      n++;
      @(negedge aclk);
    end
  endtask

  task automatic test_reset();
    areset = 1'b1;
    tx_bus.tready = 1'b1;
    rx_bus.tvalid = 1'b0;
    rx_bus.tdata = '0; rx_bus.tkeep = '0; rx_bus.tstrb = '0; rx_bus.tlast = 1'b0;
    rx_bus.tuser = '0; rx_bus.tdest = '0; rx_bus.tid = '0;
    repeat (3) @(posedge aclk);
    #1;
    total += 3;
    if (tx_bus.tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid got=%b required=0", tx_bus.tvalid); end
    if (tx_bus.tlast !== 1'b0) begin bad++; $display("FAIL reset_tlast got=%b required=0", tx_bus.tlast); end
    if (rx_bus.tready !== 1'b0) begin bad++; $display("FAIL reset_rx_tready got=%b required=0", rx_bus.tready); end
    areset = 1'b0;
    @(posedge aclk);
    #1;
    total += 2;
    if (rx_bus.tready !== 1'b1) begin bad++; $display("FAIL post_reset_rx_tready got=%b required=1", rx_bus.tready); end
    if (tx_bus.tvalid !== 1'b0) begin bad++; $display("FAIL post_reset_tvalid got=%b required=0", tx_bus.tvalid); end
  endtask

  task automatic test_full_beat();
    int n;
    logic [15:0] rdy;
    tx_bus.tready = 1'b1;
    send_beat(32'h44332211, 4'hF, 4'hF, 1'b1, 1'b1, 1'b0, 1'b1);
    count_run(n, rdy);
    total++;
    if (n != 4) begin bad++; $display("FAIL full_run_length got=%0d required=4", n); end
    drain("full");
  endtask

  task automatic test_sparse_beat();
    int n, req;
    logic [15:0] rdy;
`ifdef LOGIC_AXI4_STREAM_UNPACKER_NULL_SKIP_EN
    req = 2;
`else
    req = 4;
`endif
    send_beat(32'h44332211, 4'h5, 4'h4, 1'b1, 1'b0, 1'b1, 1'b0);
    count_run(n, rdy);
    total++;
    if (n != req) begin bad++; $display("FAIL sparse_run_length got=%0d required=%0d", n, req); end
    drain("sparse");
  endtask

  task automatic test_back_to_back();
    int n;
    logic [15:0] rdy;
    tx_bus.tready = 1'b1;
    fork
      begin
        send_beat(32'hA3A2A1A0, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
        send_beat(32'hB3B2B1B0, 4'hF, 4'h3, 1'b1, 1'b1, 1'b1, 1'b1);
      end
      count_run(n, rdy);
    join
    total += 2;
    if (n != 8) begin bad++; $display("FAIL b2b_run_length got=%0d required=8", n); end
    if (rdy[7:0] !== 8'b1000_1000) begin bad++; $display("FAIL b2b_rx_tready_pattern got=%b required=10001000", rdy[7:0]); end
    drain("b2b");
  endtask

  task automatic test_null_beats();
    tx_bus.tready = 1'b1;
    send_beat(32'h55667788, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_beat(32'h99AABBCC, 4'h0, 4'hF, 1'b1, 1'b1, 1'b0, 1'b1);
    drain("null");
    total++;
    if (tx_bus.tvalid !== 1'b0) begin bad++; $display("FAIL null_idle_after got=%b required=0", tx_bus.tvalid); end
  endtask

  task automatic test_stall();
    bit drv_done;
    drv_done = 1'b0;
    fork
      begin
        for (int b = 0; b < 6; b++) begin
          send_beat($urandom, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        drv_done = 1'b1;
      end
      begin
        bit have_prev, prev_stall;
        logic [14:0] prev, cur;
        have_prev = 1'b0;
        prev_stall = 1'b0;
        prev = '0;
        for (int c = 0; c < 2000 && !(drv_done && exp_q.size() == 0); c++) begin
          @(negedge aclk);
          cur = {tx_bus.tvalid, tx_bus.tdata, tx_bus.tkeep, tx_bus.tstrb, tx_bus.tlast,
                 tx_bus.tuser, tx_bus.tdest, tx_bus.tid};
          if (have_prev && prev_stall) begin
            total++;
            if (cur !== prev) begin bad++; $display("FAIL stall_hold got=%h required=%h", cur, prev); end
          end
          have_prev  = 1'b1;
          prev_stall = tx_bus.tvalid && !tx_bus.tready;
          prev       = cur;
          @(posedge aclk);
          #1;
          tx_bus.tready = 1'($urandom_range(0, 1));
        end
      end
    join
    tx_bus.tready = 1'b1;
    drain("stall");
  endtask

  task automatic test_reset_mid_beat();
    int n;
    tx_bus.tready = 1'b1;
    send_beat(32'h44332211, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
    n = 0;
    do begin
      @(posedge aclk);
      #2;
      n++;
    end while (!(tx_bus.tvalid && tx_bus.tdata == 8'h33) && n < 20);
    total++;
    if (!(tx_bus.tvalid && tx_bus.tdata == 8'h33)) begin
      bad++;
      $display("FAIL mid_reach_slice2 got=%h required=33", tx_bus.tdata);
    end
    areset = 1'b1;
    #1;
    total++;
    if (tx_bus.tvalid !== 1'b0) begin bad++; $display("FAIL mid_reset_tvalid got=%b required=0", tx_bus.tvalid); end
    exp_q.delete();
    @(posedge aclk);
    @(posedge aclk);
    #1;
    areset = 1'b0;
    @(posedge aclk);
    #1;
    total += 2;
    if (rx_bus.tready !== 1'b1) begin bad++; $display("FAIL mid_release_rx_tready got=%b required=1", rx_bus.tready); end
    if (tx_bus.tvalid !== 1'b0) begin bad++; $display("FAIL mid_release_tvalid got=%b required=0", tx_bus.tvalid); end
    send_beat(32'hDDCCBBAA, 4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 1'b1);
    total++;
    if (tx_bus.tdata !== 8'hAA) begin bad++; $display("FAIL mid_next_first_slice got=%h required=aa", tx_bus.tdata); end
    drain("mid");
  endtask

  initial begin
    test_reset();
    test_full_beat();
    test_sparse_beat();
    test_back_to_back();
    test_null_beats();
    test_stall();
    test_reset_mid_beat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
